// File: rtl/mem_pkg.sv
// Shared encodings for the stall-based memory responder: FSM states,
// counter width and operation codes.
package mem_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage: combinational read port, synchronous write port.
// Contents are deliberately not reset.
module mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stall_mem_resp.sv
// Variable-latency memory responder: accepts one read/write at a time, stalls
// the initiator while busy and returns a one-cycle done (or err) pulse.
module stall_mem_resp
  import mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic [1:0]  o_dbg_state
);

  localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

  // Handshake: a request is taken when rd^wr is high outside BUSY; stall is
  // high in that cycle and throughout BUSY, and the initiator holds its
  // request until stall is low. done/err pulse for exactly one cycle.

  state_t            r_state;
  state_t            w_next;
  logic [LAT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_op;
  logic              r_mis;
  logic [15:0]       r_wdata;
  logic [15:0]       r_data_out;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_illegal;
  logic [ADDR_W-1:0] w_fin_idx;
  logic              w_fin_op;
  logic              w_fin_mis;
  logic              w_we;
  logic [15:0]       w_mem_rdata;
  logic [15:0]       w_rdata_fwd;
  logic              w_addr_unused;

  assign w_addr_unused = ^addr[15:ADDR_W+1];

  always_comb begin
    w_accept  = (r_state != BUSY) && (rd ^ wr);
    w_illegal = (r_state != BUSY) && rd && wr;
    w_next    = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_next = (LATENCY == 1) ? DONE : BUSY;
        else          w_next = IDLE;
      end
      BUSY:    if (r_cnt == LAT_W'(1)) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // With LATENCY=1 the completing request is the one being accepted now.
  always_comb begin
    w_fin_idx = r_idx;
    w_fin_op  = r_op;
    w_fin_mis = r_mis;
    if (w_accept) begin
      w_fin_idx = addr[ADDR_W:1];
      w_fin_op  = wr ? OP_WR : OP_RD;
      w_fin_mis = addr[0];
    end
  end

  assign w_we = (r_state == DONE) && (r_op == OP_WR) && !r_mis && !rst;

  // Read data is captured one edge before DONE; forward a write that commits
  // on that same edge so back-to-back read-after-write sees the new data.
  assign w_rdata_fwd = (w_we && (r_idx == w_fin_idx)) ? r_wdata : w_mem_rdata;

  mem_array #(.ADDR_W(ADDR_W), .DATA_W(16)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_fin_idx),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_op       <= OP_RD;
      r_mis      <= 1'b0;
      r_wdata    <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx   <= addr[ADDR_W:1];
        r_op    <= wr ? OP_WR : OP_RD;
        r_mis   <= addr[0];
        r_wdata <= data_in;
        r_cnt   <= LAT_M1;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
      if (w_next == DONE) begin
        r_done     <= 1'b1;
        r_err      <= w_fin_mis;
        r_data_out <= ((w_fin_op == OP_RD) && !w_fin_mis) ? w_rdata_fwd : 16'h0000;
      end else begin
        r_done     <= 1'b0;
        r_err      <= w_illegal;
        r_data_out <= 16'h0000;
      end
    end
  end

  assign stall       = (r_state == BUSY) || w_accept;
  assign done        = r_done;
  assign err         = r_err;
  assign data_out    = r_data_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stall_mem_resp.sv
// Directed bench for stall_mem_resp: a per-cycle vector table on a LATENCY=4
// instance, plus a short hand-written sequence on a LATENCY=1 instance.
module tb_stall_mem_resp;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_B = 2'd1;
  localparam logic [1:0] S_D = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=4 instance
  logic        rst, rd, wr;
  logic [15:0] addr, data_in, data_out;
  logic        done, stall, err;
  logic [1:0]  dbg_state;

  stall_mem_resp #(.LATENCY(4), .ADDR_W(10)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(data_out), .done(done), .stall(stall), .err(err),
    .o_dbg_state(dbg_state)
  );

  // LATENCY=1 instance
  logic        rst1, rd1, wr1;
  logic [15:0] addr1, data_in1, data_out1;
  logic        done1, stall1, err1;
  logic [1:0]  dbg_state1;

  stall_mem_resp #(.LATENCY(1), .ADDR_W(10)) u_dut1 (
    .clk(clk), .rst(rst1), .addr(addr1), .data_in(data_in1), .rd(rd1), .wr(wr1),
    .data_out(data_out1), .done(done1), .stall(stall1), .err(err1),
    .o_dbg_state(dbg_state1)
  );

  typedef struct {
    logic        rst, rd, wr;
    logic [15:0] addr, din;
    logic        stall, done, err;
    logic [15:0] dout;
    logic [1:0]  st;
    logic        chk;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic rdi, input logic wri, input logic [15:0] a,
                   input logic [15:0] d, input logic es, input logic ed, input logic ee,
                   input logic [15:0] eo, input logic [1:0] est);
    vec_t x;
    x.rst = r; x.rd = rdi; x.wr = wri; x.addr = a; x.din = d;
    x.stall = es; x.done = ed; x.err = ee; x.dout = eo; x.st = est; x.chk = 1'b1;
    vecs.push_back(x);
  endtask

  // Request held through BUSY: ignored by the responder, stall stays high.
  task automatic hold(input int n, input logic rdi, input logic wri,
                      input logic [15:0] a, input logic [15:0] d);
    for (int k = 0; k < n; k++) v(0, rdi, wri, a, d, 1, 0, 0, 16'h0, S_B);
  endtask

  task automatic idle_done(input logic ee, input logic [15:0] eo);
    v(0, 0, 0, 16'h0, 16'h0, 0, 1, ee, eo, S_D);
  endtask

  task automatic cyc1(input logic rdi, input logic wri, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    rst1 = 1'b0; rd1 = rdi; wr1 = wri; addr1 = a; data_in1 = d;
    @(negedge clk);
  endtask

  initial begin
    vec_t first;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; data_in1 = '0;

    first = '{rst: 1, rd: 0, wr: 0, addr: 0, din: 0, stall: 0, done: 0, err: 0,
              dout: 0, st: S_I, chk: 0};
    vecs.push_back(first);
    v(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, S_I);
    // write 0x0010 = BEEF, then read it back
    v(0, 0, 1, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0, S_I);
    hold(3, 0, 1, 16'h0010, 16'hBEEF);
    idle_done(0, 16'h0000);
    v(0, 1, 0, 16'h0010, 16'h0, 1, 0, 0, 16'h0, S_I);
    hold(3, 1, 0, 16'h0010, 16'h0);
    idle_done(0, 16'hBEEF);
    // back-to-back write then read of 0x0020
    v(0, 0, 1, 16'h0020, 16'h1234, 1, 0, 0, 16'h0, S_I);
    hold(3, 0, 1, 16'h0020, 16'h1234);
    v(0, 1, 0, 16'h0020, 16'h0, 1, 1, 0, 16'h0000, S_D);
    hold(3, 1, 0, 16'h0020, 16'h0);
    idle_done(0, 16'h1234);
    // misaligned read and write, then confirm mem[8] untouched
    v(0, 1, 0, 16'h0011, 16'h0, 1, 0, 0, 16'h0, S_I);
    hold(3, 1, 0, 16'h0011, 16'h0);
    idle_done(1, 16'h0000);
    v(0, 0, 1, 16'h0011, 16'hFFFF, 1, 0, 0, 16'h0, S_I);
    hold(3, 0, 1, 16'h0011, 16'hFFFF);
    idle_done(1, 16'h0000);
    v(0, 1, 0, 16'h0010, 16'h0, 1, 0, 0, 16'h0, S_I);
    hold(3, 1, 0, 16'h0010, 16'h0);
    idle_done(0, 16'hBEEF);
    // illegal rd+wr
    v(0, 1, 1, 16'h0000, 16'h0, 0, 0, 0, 16'h0, S_I);
    v(0, 0, 0, 16'h0000, 16'h0, 0, 0, 1, 16'h0, S_I);
    v(0, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0, S_I);
    // reset mid-write: seed 0x0030 = 1111 first
    v(0, 0, 1, 16'h0030, 16'h1111, 1, 0, 0, 16'h0, S_I);
    hold(3, 0, 1, 16'h0030, 16'h1111);
    idle_done(0, 16'h0000);
    v(0, 0, 1, 16'h0030, 16'hAAAA, 1, 0, 0, 16'h0, S_I);
    hold(1, 0, 1, 16'h0030, 16'hAAAA);
    v(1, 0, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h0, S_B);
    for (int k = 0; k < 3; k++) v(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, S_I);
    v(0, 1, 0, 16'h0030, 16'h0, 1, 0, 0, 16'h0, S_I);
    hold(3, 1, 0, 16'h0030, 16'h0);
    idle_done(0, 16'h1111);
    // address aliasing: 0x0802 and 0x0002 map to the same word
    v(0, 0, 1, 16'h0802, 16'h5A5A, 1, 0, 0, 16'h0, S_I);
    hold(3, 0, 1, 16'h0802, 16'h5A5A);
    idle_done(0, 16'h0000);
    v(0, 1, 0, 16'h0002, 16'h0, 1, 0, 0, 16'h0, S_I);
    hold(3, 1, 0, 16'h0002, 16'h0);
    idle_done(0, 16'h5A5A);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; rd = vecs[i].rd; wr = vecs[i].wr;
      addr = vecs[i].addr; data_in = vecs[i].din;
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("v%0d stall", i), {15'h0, stall}, {15'h0, vecs[i].stall});
        check($sformatf("v%0d done", i), {15'h0, done}, {15'h0, vecs[i].done});
        check($sformatf("v%0d err", i), {15'h0, err}, {15'h0, vecs[i].err});
        check($sformatf("v%0d state", i), {14'h0, dbg_state}, {14'h0, vecs[i].st});
        if (vecs[i].done) check($sformatf("v%0d data_out", i), data_out, vecs[i].dout);
      end
    end

    // LATENCY=1: write, back-to-back read of the same word, misaligned read
    @(posedge clk); #1; rst1 = 1'b1;
    @(posedge clk); #1;
    cyc1(0, 1, 16'h0040, 16'h0F0F);
    check("l1 wr stall", {15'h0, stall1}, 16'h1);
    check("l1 wr state", {14'h0, dbg_state1}, {14'h0, S_I});
    cyc1(1, 0, 16'h0040, 16'h0);
    check("l1 wr done", {15'h0, done1}, 16'h1);
    check("l1 rd accept stall", {15'h0, stall1}, 16'h1);
    check("l1 wr done state", {14'h0, dbg_state1}, {14'h0, S_D});
    cyc1(0, 0, 16'h0, 16'h0);
    check("l1 rd done", {15'h0, done1}, 16'h1);
    check("l1 rd data_out", data_out1, 16'h0F0F);
    check("l1 rd stall", {15'h0, stall1}, 16'h0);
    check("l1 rd err", {15'h0, err1}, 16'h0);
    cyc1(0, 0, 16'h0, 16'h0);
    check("l1 done clears", {15'h0, done1}, 16'h0);
    check("l1 idle state", {14'h0, dbg_state1}, {14'h0, S_I});
    cyc1(1, 0, 16'h0041, 16'h0);
    check("l1 mis stall", {15'h0, stall1}, 16'h1);
    cyc1(0, 0, 16'h0, 16'h0);
    check("l1 mis done", {15'h0, done1}, 16'h1);
    check("l1 mis err", {15'h0, err1}, 16'h1);
    check("l1 mis data_out", data_out1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stall_mem_resp.md
Name: stall_mem_resp

Overview:
Multicycle memory responder serving the processor's fetch and data-memory initiators. It replaces the single-cycle memory model with a variable-latency responder.
- Accepts one read or write request at a time.
- Holds the initiator off with stall.
- Returns completion with a one-cycle done pulse.
- Sits between the pc/fetch logic or load/store unit and a word-organised storage array.

Parameters:
LATENCY  4   cycles from request acceptance to done; legal range 1..15
ADDR_W   10  word-address bits; storage depth is 2^ADDR_W 16-bit words

Ports:
clk         input   1   system clock; all state changes on its rising edge
rst         input   1   synchronous, active-high reset
addr        input   16  byte address; bit 0 is the alignment bit; word index is addr[ADDR_W:1]
data_in     input   16  write data
rd          input   1   read request
wr          input   1   write request
data_out    output  16  read data; valid only while done=1
done        output  1   one-cycle completion pulse
stall       output  1   initiator must hold its request and PC while high
err         output  1   one-cycle error pulse

Behaviour:
- Reset (rst=1 at a clock edge):
  - state <= IDLE; data_out <= 0; done <= 0; err <= 0; counter <= 0.
  - Storage contents are NOT cleared.
  - An in-flight request is aborted; a pending write is discarded.
- States: IDLE, BUSY, DONE.
- Acceptance:
  - A request is accepted in IDLE or DONE when exactly one of rd/wr is 1.
  - On acceptance: latch addr, data_in and op; counter <= LATENCY-1; state <= BUSY.
  - If LATENCY=1, state goes directly to DONE.
- BUSY:
  - counter decrements each cycle; rd/wr/addr/data_in are ignored.
  - When counter=1, state <= DONE.
- DONE (exactly cycle T+LATENCY, where T is the accept cycle):
  - done=1.
  - Read: data_out = mem[latched word index].
  - Write: mem[latched index] <= latched data, committed at the end of the DONE cycle; data_out = 0.
  - Next state is IDLE unless a new request is accepted in the same cycle (back-to-back), in which case next state is BUSY.
- stall (combinational):
  - 1 in an accept cycle and in every BUSY cycle; 0 in the DONE cycle.
  - stall = (state==BUSY) | accept.
- Read-after-write, back-to-back to the same address: the read accepted in the write's DONE cycle returns the new data.
- Misaligned (latched addr[0]=1):
  - Full latency still elapses.
  - In the DONE cycle: done=1, err=1, data_out=0, no write commit.
- Illegal op (rd=1 and wr=1 in IDLE/DONE):
  - Not accepted; no stall.
  - err=1 in the next cycle for one cycle; done stays 0; state -> IDLE.
- Address wrap: bits addr[15:ADDR_W+1] are ignored, so addresses alias modulo 2^(ADDR_W+1) bytes.
- Outputs done, err and data_out are registered (driven from state/latched values); stall is the only combinational output.
- No request is ever queued. The initiator must hold rd/wr asserted until stall drops; a request that drops during BUSY is still completed.

Decomposition:
- Shared package mem_pkg:
  - state encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - counter width constant LAT_W=4
  - op encoding OP_RD=1'b0, OP_WR=1'b1
- One sub-module mem_array: 2^ADDR_W x 16 storage with combinational read port and synchronous write-enable port, no reset.
- FSM, counter and latches live in stall_mem_resp.

Test Plan:
- Reset, then write: with LATENCY=4, write addr=0x0010, data=0xBEEF at cycle 0.
  - Required: stall=1 for cycles 0-3; done=1 at cycle 4 only; err=0.
  - A subsequent read of 0x0010 returns data_out=0xBEEF with done at +4 cycles.
- Back-to-back: write 0x0020=0x1234; in its DONE cycle assert a read of 0x0020.
  - Required: the read is accepted without an IDLE gap; its done arrives 4 cycles later with data_out=0x1234.
- Misaligned read of addr=0x0011.
  - Required: stall for 4 cycles, then done=1, err=1, data_out=0x0000.
  - A misaligned write leaves mem[8] unchanged, verified by a read of 0x0010.
- Illegal op: rd=1, wr=1 in IDLE.
  - Required: stall=0; err=1 in the following cycle only; done never asserts; state IDLE.
- Reset mid-write: write 0x0030=0xAAAA, assert rst in cycle 2.
  - Required: done never pulses; stall=0 after reset.
  - A read of 0x0030 returns the pre-write value.
- Boundary/parameter checks:
  - LATENCY=1: read completes with done in the cycle after acceptance.
  - ADDR_W=10: addr 0x0802 aliases 0x0002 (write 0x5A5A via 0x0802, read 0x0002 -> 0x5A5A).
